prog_counter: RTL and testbench
===============================

// Module: prog_counter
// PURPOSE
//   Loadable up-counter for a program counter (PC).
//   Holds the current instruction address on Y.
//   Advances by one per clock when enabled, or takes a jump/branch target from A.
//   Sits between the instruction fetch address mux and the instruction memory address port.
// PARAMETERS
//   WIDTH      8    counter/address width in bits
//   RESET_VAL  0    value loaded into Y by Reset (WIDTH bits)
// PORTS
//   Clk      in   1      rising-edge clock; all state changes on posedge Clk
//   Reset    in   1      synchronous, active-high reset
//   A        in   WIDTH  parallel load value (jump target)
//   CountEn  in   1      increment enable
//   Load     in   1      parallel load enable
//   Y        out  WIDTH  registered counter value (current PC)
//   Wrap     out  1      only with PROGCOUNT_WRAP_FLAG_EN; see CONFIGURATION
// BEHAVIOUR
//   - Single register. Y is driven directly from the flop, with no combinational path from inputs.
//   - Priority at each posedge Clk, highest first:
//       1. Reset=1                -> Y <= RESET_VAL
//       2. Load=1                 -> Y <= A (CountEn ignored)
//       3. CountEn=1              -> Y <= Y + 1, modulo 2**WIDTH
//       4. otherwise              -> Y holds
//   - Latency: exactly one clock from sampled inputs to the new Y.
//   - Wrap-around: 2**WIDTH-1 + 1 -> 0 (255 -> 0 for WIDTH=8). No saturation, no error flag.
//   - Reset mid-count or during Load: Reset wins and Y = RESET_VAL on that edge.
//     Counting resumes on the first edge with Reset=0.
//   - Load and CountEn both set: the loaded value is A, not A+1.
//   - Before the first Reset edge, Y is undefined. The bench must apply Reset first.
//   - X on Load/CountEn when Reset=1 must not corrupt Y.
// CONFIGURATION
//   PROGCOUNT_WRAP_FLAG_EN defined:
//     - Adds output Wrap.
//     - Wrap is registered and goes high for exactly one cycle, coincident with Y,
//       when Y advanced by increment from all-ones to 0.
//     - A Load of 0 does not set Wrap.
//     - Reset clears Wrap to 0.
//   PROGCOUNT_WRAP_FLAG_EN undefined:
//     - Wrap port and its logic are absent.
//     - Behaviour of Y is identical in both builds.
// STRUCTURE
//   - Package prog_counter_pkg:
//       - PC_WIDTH (default 8) and PC_RESET_VAL constants
//       - typedef pc_t = logic [PC_WIDTH-1:0]
//       - enum pc_op_e {PC_RESET, PC_LOAD, PC_INC, PC_HOLD}, used for next-state selection
//   - One sub-module, pc_incr:
//       - combinational WIDTH-bit +1
//       - outputs sum and carry-out
//       - carry-out feeds the Wrap logic
//   - The top is a priority mux plus the register.
// TESTING
//   - Reset: Reset=1, CountEn=1, A=1 for one edge -> Y=0; Wrap=0 if enabled.
//   - Load: Reset=0, Load=1, CountEn=0, A=1 -> Y=1 after one edge.
//   - Hold: Load=0, CountEn=0, A=3 -> Y stays 1; A is ignored.
//   - Count: Load=0, CountEn=1 -> Y=2 after one edge.
//   - Load priority and wrap:
//       - Load=1, CountEn=1, A=254 -> Y=254.
//       - Then Load=0, CountEn=1 -> Y = 255, 0, 1, 2 on successive edges.
//       - With PROGCOUNT_WRAP_FLAG_EN, Wrap=1 only in the cycle where Y=0.
//   - Mid-count reset: while counting at Y=100, assert Reset for one edge -> Y=0.
//     Next edge with CountEn=1 -> Y=1.

Source files
------------

// File: rtl/prog_counter_pkg.sv
// Shared types and constants for the loadable program counter.
// Optional wrap flag is enabled by defining PROGCOUNT_WRAP_FLAG_EN.
package prog_counter_pkg;

    localparam int PC_WIDTH = 8;

    typedef logic [PC_WIDTH-1:0] pc_t;

    localparam pc_t PC_RESET_VAL = '0;

    // Next-state selection, listed in priority order.
    typedef enum logic [1:0] {
        PC_RESET,
        PC_LOAD,
        PC_INC,
        PC_HOLD
    } pc_op_e;

endpackage

// File: rtl/prog_counter_if.sv
// Control/data bundle between the fetch address mux and the program counter.
// Wrap exists only when PROGCOUNT_WRAP_FLAG_EN is defined.
interface prog_counter_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] A;
    logic             CountEn;
    logic             Load;
    logic [WIDTH-1:0] Y;
`ifdef PROGCOUNT_WRAP_FLAG_EN
    logic             Wrap;
`endif

`ifdef PROGCOUNT_WRAP_FLAG_EN
    modport master (output A, output CountEn, output Load, input Y, input Wrap);
    modport slave  (input A, input CountEn, input Load, output Y, output Wrap);
`else
    modport master (output A, output CountEn, output Load, input Y);
    modport slave  (input A, input CountEn, input Load, output Y);
`endif
endinterface

// File: rtl/prog_counter_pc_incr.sv
// Combinational WIDTH-bit increment; carry-out marks the all-ones -> 0 rollover.
module pc_incr #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);
    assign {carry_o, sum_o} = {1'b0, a_i} + (WIDTH + 1)'(1);
endmodule

// File: rtl/prog_counter.sv
// Program counter: reset > load > increment > hold, single registered output.
// Define PROGCOUNT_WRAP_FLAG_EN to add the registered one-cycle Wrap flag.
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int               WIDTH     = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(PC_RESET_VAL)
) (
    input  logic          Clk,
    input  logic          Reset,
    prog_counter_if.slave bus
);
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] y_d;
    logic [WIDTH-1:0] inc_sum;
    logic             inc_carry;
    pc_op_e           op;

    pc_incr #(.WIDTH(WIDTH)) u_incr (
        .a_i     (y_q),
        .sum_o   (inc_sum),
        .carry_o (inc_carry)
    );

    // Reset is tested first so unknown Load/CountEn cannot leak into Y.
    always_comb begin
        op = PC_HOLD;
        if (Reset)
            op = PC_RESET;
        else if (bus.Load)
            op = PC_LOAD;
        else if (bus.CountEn)
            op = PC_INC;
    end

    always_comb begin
        y_d = y_q;
        case (op)
            PC_RESET: y_d = RESET_VAL;
            PC_LOAD:  y_d = bus.A;
            PC_INC:   y_d = inc_sum;
            default:  y_d = y_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        y_q <= y_d;
    end

    assign bus.Y = y_q;

`ifdef PROGCOUNT_WRAP_FLAG_EN
    logic wrap_q;
    logic wrap_d;

    // Only a true rollover by increment flags; loading 0 does not.
    always_comb begin
        wrap_d = 1'b0;
        if (op == PC_INC)
            wrap_d = inc_carry;
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            wrap_q <= 1'b0;
        else
            wrap_q <= wrap_d;
    end

    assign bus.Wrap = wrap_q;
`else
    logic unused_carry;
    assign unused_carry = inc_carry;
`endif

endmodule

// File: tb/tb_prog_counter.sv
// Directed table-driven bench for prog_counter, plus hand sequences for
// wrap, mid-count reset and unknown controls during reset.
module tb_prog_counter;
    import prog_counter_pkg::*;

    localparam int W = 8;

    logic Clk;
    logic Reset;
    int   checks;
    int   errors;

    prog_counter_if #(.WIDTH(W)) bus ();

    prog_counter #(.WIDTH(W), .RESET_VAL(8'd0)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       load;
        logic       cnt;
        logic [7:0] a;
        logic [7:0] exp_y;
        logic       exp_wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string n, input logic r, input logic l, input logic c,
                       input logic [7:0] a, input logic [7:0] y, input logic w);
        vec_t v;
        v.name = n; v.rst = r; v.load = l; v.cnt = c; v.a = a; v.exp_y = y; v.exp_wrap = w;
        vecs.push_back(v);
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic l, input logic c, input logic [7:0] a);
        @(negedge Clk);
        Reset = r; bus.Load = l; bus.CountEn = c; bus.A = a;
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string n, input logic [7:0] exp_y, input logic exp_w);
        checks++;
        if (bus.Y !== exp_y) begin
            errors++;
            $display("FAIL %s: Y got %0d expected %0d", n, bus.Y, exp_y);
        end
        $display("txn %s: Y=%0d (expected %0d)", n, bus.Y, exp_y);
`ifdef PROGCOUNT_WRAP_FLAG_EN
        checks++;
        if (bus.Wrap !== exp_w) begin
            errors++;
            $display("FAIL %s_wrap: Wrap got %b expected %b", n, bus.Wrap, exp_w);
        end
`else
        if (exp_w === 1'bx) $display("txn %s: unexpected unknown wrap expectation", n);
`endif
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [7:0] model_y;
        logic       model_w;
        checks = 0;
        errors = 0;
        Reset = 1'b0; bus.Load = 1'b0; bus.CountEn = 1'b0; bus.A = '0;

        //   name         rst  load cnt  A      Y    Wrap
        add("reset",      1,   0,   1,   1,     0,   0);
        add("load1",      0,   1,   0,   1,     1,   0);
        add("hold",       0,   0,   0,   3,     1,   0);
        add("count",      0,   0,   1,   3,     2,   0);
        add("load_prio",  0,   1,   1,   254,   254, 0);
        add("inc255",     0,   0,   1,   0,     255, 0);
        add("wrap0",      0,   0,   1,   0,     0,   1);
        add("inc1",       0,   0,   1,   0,     1,   0);
        add("inc2",       0,   0,   1,   0,     2,   0);
        add("load99",     0,   1,   0,   99,    99,  0);
        add("inc100",     0,   0,   1,   0,     100, 0);
        add("rst_mid",    1,   0,   1,   0,     0,   0);
        add("resume1",    0,   0,   1,   0,     1,   0);
        add("load255",    0,   1,   0,   255,   255, 0);
        add("load0",      0,   1,   0,   0,     0,   0);
        add("hold0",      0,   0,   0,   55,    0,   0);
        add("load77",     0,   1,   0,   77,    77,  0);
        add("rst_load",   1,   1,   1,   200,   0,   0);
        add("rst_again",  1,   0,   0,   9,     0,   0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].load, vecs[i].cnt, vecs[i].a);
            check(vecs[i].name, vecs[i].exp_y, vecs[i].exp_wrap);
        end

        // Unknown controls while in reset must not disturb Y.
        step(1'b0, 1'b1, 1'b0, 8'd42);
        check("pre_x", 8'd42, 1'b0);
        step(1'b1, 1'bx, 1'bx, 8'hxx);
        check("rst_x", 8'd0, 1'b0);

        // Run across the rollover; Wrap only on the edge that lands on 0.
        step(1'b0, 1'b1, 1'b0, 8'd250);
        check("load250", 8'd250, 1'b0);
        model_y = 8'd250;
        for (int k = 0; k < 9; k++) begin
            model_w = (model_y == 8'hFF);
            model_y = model_y + 8'd1;
            step(1'b0, 1'b0, 1'b1, 8'd0);
            check($sformatf("run%0d", k), model_y, model_w);
        end

        // Wrap lasts exactly one cycle when counting stops right after the rollover.
        step(1'b0, 1'b1, 1'b0, 8'd255);
        check("load255b", 8'd255, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'd0);
        check("wrap_b", 8'd0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        check("wrap_clear", 8'd0, 1'b0);

        // Reset on the rollover edge beats the increment and clears Wrap.
        step(1'b0, 1'b1, 1'b0, 8'd255);
        check("load255c", 8'd255, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'd0);
        check("rst_at_wrap", 8'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
